// File: rtl/seg_disp_pkg.sv
// Shared types and board constants for the seven-segment display arbiter.
package seg_disp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } seg_disp_state_t;

    localparam int unsigned SEG_WORD_W = 32;
    localparam logic [SEG_WORD_W-1:0] SEG_DEFAULT_WORD = 32'h0000_0000;

    // Requester slots as wired on the board
    localparam int unsigned SRC_CPU_DBG = 0;
    localparam int unsigned SRC_REGVIEW = 1;
    localparam int unsigned SRC_STATUS  = 2;
    localparam int unsigned SRC_ERROR   = 3;

endpackage

// File: rtl/seg_rr_picker.sv
// Combinational round-robin search: first eligible request at or after start, wrapping.
module seg_rr_picker #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] start,
    input  logic [NUM_SRC-1:0]         excl,
    output logic                       found,
    output logic [$clog2(NUM_SRC)-1:0] winner
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] eligible;
    int unsigned        pos;
    logic [IDX_W-1:0]   pos_idx;

    assign eligible = req & ~excl;

    always_comb begin
        found   = 1'b0;
        winner  = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pos = 32'(start) + i;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            pos_idx = pos[IDX_W-1:0];
            if (!found && eligible[pos_idx]) begin
                found  = 1'b1;
                winner = pos_idx;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration with minimum dwell for the shared 8-digit display.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned           NUM_SRC      = 4,
    parameter int unsigned           DWELL_CYCLES = 100_000_000,
    parameter logic [SEG_WORD_W-1:0] DEFAULT_WORD = SEG_DEFAULT_WORD
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0]                  req,
    input  logic [NUM_SRC-1:0][SEG_WORD_W-1:0]  src_data,
    output logic [NUM_SRC-1:0]                  grant,
    output logic                                owner_valid,
    output logic [$clog2(NUM_SRC)-1:0]          owner_id,
    output logic [SEG_WORD_W-1:0]               disp_data
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    seg_disp_state_t    state;
    logic [CNT_W-1:0]   dwell_cnt;
    logic [IDX_W-1:0]   last_owner;

    logic [IDX_W-1:0]   start_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_id;
    logic [NUM_SRC-1:0] pick_onehot;
    logic               do_grant;
    logic               do_idle;

    assign start_idx = (last_owner == IDX_W'(NUM_SRC - 1)) ? '0 : last_owner + IDX_W'(1);

    // grant is zero in IDLE, so it doubles as the "exclude current owner" mask
    seg_rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req    (req),
        .start  (start_idx),
        .excl   (grant),
        .found  (pick_found),
        .winner (pick_id)
    );

    always_comb begin
        pick_onehot          = '0;
        pick_onehot[pick_id] = 1'b1;
    end

    always_comb begin
        do_grant = 1'b0;
        do_idle  = 1'b0;
        case (state)
            IDLE: begin
                do_grant = pick_found;
            end
            OWNED: begin
                if (!req[owner_id]) begin
                    do_grant = pick_found;
                    do_idle  = !pick_found;
                end else if (dwell_cnt == '0) begin
                    do_grant = pick_found;
                end
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dwell_cnt   <= '0;
            last_owner  <= IDX_W'(NUM_SRC - 1);
            grant       <= '0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
            disp_data   <= DEFAULT_WORD;
        end else begin
            // Uses the pre-edge owner, so a new owner's word lands one cycle after its grant
            disp_data <= owner_valid ? src_data[owner_id] : DEFAULT_WORD;

            if (do_grant) begin
                state       <= OWNED;
                dwell_cnt   <= DWELL_LOAD;
                last_owner  <= pick_id;
                grant       <= pick_onehot;
                owner_valid <= 1'b1;
                owner_id    <= pick_id;
            end else if (do_idle) begin
                state       <= IDLE;
                dwell_cnt   <= '0;
                grant       <= '0;
                owner_valid <= 1'b0;
                owner_id    <= '0;
            end else if (state == OWNED && dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scoreboard bench for seg_display_arbiter (4 sources, dwell 8).
module tb_seg_display_arbiter;

    localparam int unsigned NS  = 4;
    localparam int unsigned DW  = 8;
    localparam logic [31:0] DEF = 32'hDEAD_0000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NS-1:0]       req;
    logic [NS-1:0][31:0] src_data;
    logic [NS-1:0]       grant;
    logic                owner_valid;
    logic [1:0]          owner_id;
    logic [31:0]         disp_data;

    typedef struct packed {
        logic [3:0]  g;
        logic [31:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] prev_g;
    int         checks = 0;
    int         errors = 0;

    seg_display_arbiter #(
        .NUM_SRC      (NS),
        .DWELL_CYCLES (DW),
        .DEFAULT_WORD (DEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .src_data    (src_data),
        .grant       (grant),
        .owner_valid (owner_valid),
        .owner_id    (owner_id),
        .disp_data   (disp_data)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] eg, input logic [31:0] ed);
        chk({tag, ".grant"}, {28'b0, grant}, {28'b0, eg});
        chk({tag, ".disp"}, disp_data, ed);
        chk({tag, ".valid"}, {31'b0, owner_valid}, {31'b0, |eg});
        chk({tag, ".id"}, {30'b0, owner_id}, 32'(idx_of(eg)));
        chk({tag, ".onehot"}, {31'b0, $onehot0(grant)}, 32'd1);
    endtask

    // Push expectation for the coming edge, then pop and compare after it.
    task automatic tick(input string tag, input logic [3:0] eg);
        exp_t e;
        e.g = eg;
        e.d = (prev_g == 4'b0) ? DEF : src_data[idx_of(prev_g)];
        sb.push_back(e);
        prev_g = eg;
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk_outputs(tag, e.g, e.d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        req         = 4'b0000;
        src_data[0] = 32'hC0C0_0000;
        src_data[1] = 32'h1111_1111;
        src_data[2] = 32'h1234_5678;
        src_data[3] = 32'h3333_3333;
        prev_g      = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs("reset", 4'b0000, DEF);
        rst_n = 1'b1;

        // Single requester, live data follow, release to idle
        req = 4'b0100;
        tick("a_grant", 4'b0100);
        tick("a_word", 4'b0100);
        src_data[2] = 32'h0000_00AB;
        tick("a_follow", 4'b0100);
        req = 4'b0000;
        tick("a_drop", 4'b0000);
        tick("a_idle", 4'b0000);

        // Source 0 owns, others join: dwell then rotation 1,3,0
        req = 4'b0001;
        tick("b_grant0", 4'b0001);
        req = 4'b1011;
        for (int i = 0; i < 7; i++) tick("b_dwell0", 4'b0001);
        for (int i = 0; i < 8; i++) tick("b_own1", 4'b0010);
        for (int i = 0; i < 8; i++) tick("b_own3", 4'b1000);
        for (int i = 0; i < 8; i++) tick("b_wrap0", 4'b0001);

        // Owner 1 drops at dwell count 5 with source 3 waiting
        for (int i = 0; i < 3; i++) tick("c_own1", 4'b0010);
        req = 4'b1001;
        tick("c_switch3", 4'b1000);

        // Lone owner holds past dwell, then releases
        req = 4'b1000;
        for (int i = 0; i < 50; i++) tick("d_hold3", 4'b1000);
        req = 4'b0000;
        tick("d_drop", 4'b0000);
        tick("d_idle", 4'b0000);

        // All requesting: strict 0,1,2,3 rotation
        req = 4'b1111;
        for (int k = 0; k < 100; k++) begin
            tick("e_rr", 4'(1) << ((k / DW) % NS));
        end

        // Asynchronous reset mid-ownership
        #2 rst_n = 1'b0;
        #1 chk_outputs("f_async_rst", 4'b0000, DEF);
        @(negedge clk);
        chk_outputs("f_rst_hold", 4'b0000, DEF);
        rst_n  = 1'b1;
        prev_g = 4'b0000;
        for (int i = 0; i < 8; i++) tick("f_restart0", 4'b0001);
        tick("f_next1", 4'b0010);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 8-digit seven-segment display between up to NUM_SRC requesters (CPU debug port, register viewer, status/error reporter, ...). Uses round-robin arbitration with a guaranteed minimum dwell time per owner. Drives the registered 32-bit word that feeds the seven-segment display controller's `data` input, plus one-hot grants back to the requesters.

## Interface
- `NUM_SRC`, default 4: number of requesters, 2..8.
- `DWELL_CYCLES`, default 100_000_000: minimum ownership time in clk cycles (1 s at 100 MHz), must be ≥1.
- `DEFAULT_WORD`, default 32'h0000_0000: word shown when no source owns the display.
- Clock and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `req` input, NUM_SRC bits: per-source display request, level-sensitive.
- `src_data` input, NUM_SRC×32 bits (packed array): per-source display word, 8 hex nibbles, nibble 0 = rightmost digit.
- `grant` output, NUM_SRC bits: one-hot current owner, all zero when idle.
- `owner_valid` output, 1 bit: a source owns the display.
- `owner_id` output, $clog2(NUM_SRC) bits: index of owner, 0 when idle.
- `disp_data` output, 32 bits: word to the seven-segment display controller.

## Operation
- FSM states: IDLE and OWNED.
- IDLE:
  - grant=0, owner_valid=0, `disp_data`=DEFAULT_WORD.
  - If any `req` bit is set, pick a winner round-robin, go to OWNED, and load the dwell counter with DWELL_CYCLES−1.
- Round-robin rule:
  - Search starts at (last_owner+1) mod NUM_SRC and wraps; the first set `req` bit wins.
  - last_owner updates on every grant.
- OWNED, per cycle, in priority order:
  1. Owner's `req`=0: release immediately. If another `req` is set, switch directly to the next winner (no IDLE cycle) and reload the counter; otherwise go to IDLE.
  2. Dwell counter ≠0: decrement and hold. Other requests are ignored.
  3. Dwell counter =0 and some other `req` is set: switch to the round-robin winner among the other sources and reload the counter.
  4. Dwell counter =0 and no other `req`: the owner keeps the display indefinitely; the counter stays 0.
- `disp_data` is a registered mux of `src_data[owner]` and follows live updates from the owner while it owns the display.
- The counter width is $clog2(DWELL_CYCLES+1). The counter saturates at 0 and never wraps.

## Timing
- Reset values: grant=0, owner_valid=0, owner_id=0, `disp_data`=DEFAULT_WORD, state=IDLE, counter=0, last_owner=NUM_SRC−1 (first search begins at source 0).
- Reset asserted mid-ownership returns all of the above on the same edge, with no grant glitch.
- `req` is sampled at edge N, and `grant`/`owner_valid`/`owner_id` are registered at edge N. They are visible in cycle N+1.
- `disp_data` reflects `src_data[owner]` one cycle after the grant, so the first owner word appears at edge N+1.
- A `src_data` change is visible on `disp_data` one cycle later.
- On a switch, the old owner's `grant` falls and the new owner's `grant` rises on the same edge. `disp_data` shows the old word for exactly one more cycle, then the new word. In no cycle is `grant` anything other than one-hot or zero.
- Once granted, an owner keeps the display for at least DWELL_CYCLES cycles unless it drops `req`.
- Simultaneous owner drop and a new request from another source: direct switch on that edge.
- If the owner drops `req` and immediately re-raises it while others wait, it rejoins the rotation as a normal requester.

## Structure
- Package `seg_disp_pkg`:
  - `seg_disp_state_t` enum {IDLE, OWNED}.
  - `SEG_WORD_W`=32.
  - `SEG_DEFAULT_WORD`.
  - Source-index constants for the board (SRC_CPU_DBG=0, SRC_REGVIEW=1, SRC_STATUS=2, SRC_ERROR=3).
- Sub-module `seg_rr_picker`, combinational:
  - Inputs: `req` vector, start index, exclude-mask.
  - Outputs: `found` and winner index.
  - Instantiated once.
- Top module holds the FSM, dwell counter, last_owner and output registers.

## Test plan
Bench parameters: NUM_SRC=4, DWELL_CYCLES=8, DEFAULT_WORD=32'hDEAD_0000.
- Reset with req=4'b0000 → `disp_data`=32'hDEAD_0000, grant=0. Assert rst_n mid-ownership → same values on the reset edge.
- req=4'b0100, src_data[2]=32'h1234_5678 → grant=4'b0100 next cycle, `disp_data`=32'h1234_5678 one cycle later. Change src_data[2] to 32'h0000_00AB → `disp_data` follows after 1 cycle.
- Source 0 owns, then req=4'b1011 is raised on the cycle after the grant → grant stays 4'b0001 for exactly 8 cycles, then 4'b0010, then 4'b1000, then 4'b0001 (round-robin wrap).
- Owner 1 drops `req` at dwell count 5 while req[3]=1 → grant goes 4'b0010→4'b1000 on the same edge, with no idle cycle.
- Single owner with no competitors for 50 cycles → grant unchanged; then it drops `req` → IDLE, `disp_data`=32'hDEAD_0000 one cycle later.
- All four requesting continuously for 100 cycles → each source is granted in the order 0,1,2,3 repeating. An assertion checks `grant` is one-hot or zero every cycle.
